// File: rtl/microwave_timer_ctrl_if.sv
// Panel/keypad and counter-chain signals of the microwave timer sequencer.
// Handshake: key_valid, start and stop are one-cycle strobes with no ready; a strobe is consumed on the edge that sees it.
interface microwave_timer_ctrl_if;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       start;
    logic       stop;
    logic       door_closed;
    logic       zero_sec;
    logic       zero_tens;
    logic       zero_min;

    logic       loadn;
    logic       count_en;
    logic       timer_clrn;
    logic [3:0] data_sec;
    logic [3:0] data_tens;
    logic [3:0] data_min;
    logic       mag_on;
    logic       alarm;
    logic       err;
    logic [2:0] state;

    modport master (
        output key_valid, key_digit, start, stop, door_closed,
        output zero_sec, zero_tens, zero_min,
        input  loadn, count_en, timer_clrn, data_sec, data_tens, data_min,
        input  mag_on, alarm, err, state
    );

    modport slave (
        input  key_valid, key_digit, start, stop, door_closed,
        input  zero_sec, zero_tens, zero_min,
        output loadn, count_en, timer_clrn, data_sec, data_tens, data_min,
        output mag_on, alarm, err, state
    );
endinterface

// File: rtl/microwave_timer_ctrl.sv
// M:SS cook-timer sequencer: keypad entry, chain load, 1 s tick generation,
// door interlock, magnetron enable and end-of-cook alarm. All outputs registered.
module microwave_timer_ctrl #(
    parameter int TICK_DIV  = 100,
    parameter int DONE_HOLD = 3
) (
    input  logic                  clk,
    input  logic                  clearn,
    microwave_timer_ctrl_if.slave bus
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int HW = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(DONE_HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_COOK  = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        st, st_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [HW-1:0] hold, hold_nxt;
    logic [3:0]    entry_sec, entry_tens, entry_min;
    logic [3:0]    sec_nxt, tens_nxt, min_nxt;

    logic loadn_q, count_en_q, timer_clrn_q, mag_on_q, alarm_q, err_q;
    logic loadn_nxt, count_en_nxt, timer_clrn_nxt, err_nxt;

    logic key_ok;
    logic entry_zero;
    logic start_ok;
    logic chain_zero;

    // A digit strobe only counts when it is a real BCD digit; an ignored
    // key (>9) does not suppress a simultaneous start.
    assign key_ok     = bus.key_valid && (bus.key_digit <= 4'd9);
    assign entry_zero = (entry_sec == 4'd0) && (entry_tens == 4'd0) && (entry_min == 4'd0);
    assign start_ok   = bus.door_closed && !entry_zero && (entry_tens <= 4'd5);
    assign chain_zero = bus.zero_sec && bus.zero_tens && bus.zero_min;

    always_comb begin
        st_nxt         = st;
        presc_nxt      = presc;
        hold_nxt       = hold;
        sec_nxt        = entry_sec;
        tens_nxt       = entry_tens;
        min_nxt        = entry_min;
        loadn_nxt      = 1'b1;
        count_en_nxt   = 1'b0;
        timer_clrn_nxt = 1'b1;
        err_nxt        = 1'b0;

        case (st)
            S_IDLE: begin
                if (bus.stop) begin
                    sec_nxt        = 4'd0;
                    tens_nxt       = 4'd0;
                    min_nxt        = 4'd0;
                    timer_clrn_nxt = 1'b0;
                end else if (key_ok) begin
                    min_nxt  = entry_tens;
                    tens_nxt = entry_sec;
                    sec_nxt  = bus.key_digit;
                end else if (bus.start) begin
                    if (start_ok) begin
                        st_nxt    = S_LOAD;
                        loadn_nxt = 1'b0;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end

            S_LOAD: begin
                presc_nxt = '0;
                sec_nxt   = 4'd0;
                tens_nxt  = 4'd0;
                min_nxt   = 4'd0;
                st_nxt    = S_COOK;
            end

            S_COOK: begin
                // Interlock first, then end-of-cook, then the tick; a pending
                // tick at 0:00 is dropped so the chain never wraps.
                if (bus.stop || !bus.door_closed) begin
                    st_nxt = S_PAUSE;
                end else if (chain_zero) begin
                    st_nxt    = S_DONE;
                    presc_nxt = '0;
                    hold_nxt  = '0;
                end else if (presc == PRESC_LAST) begin
                    count_en_nxt = 1'b1;
                    presc_nxt    = '0;
                end else begin
                    presc_nxt = presc + PW'(1);
                end
            end

            S_PAUSE: begin
                if (bus.stop) begin
                    st_nxt         = S_IDLE;
                    timer_clrn_nxt = 1'b0;
                end else if (bus.start && bus.door_closed) begin
                    st_nxt = S_COOK;
                end
            end

            S_DONE: begin
                if (bus.stop || !bus.door_closed) begin
                    st_nxt    = S_IDLE;
                    presc_nxt = '0;
                    hold_nxt  = '0;
                end else if (presc == PRESC_LAST) begin
                    presc_nxt = '0;
                    if (hold == HOLD_LAST) begin
                        st_nxt   = S_IDLE;
                        hold_nxt = '0;
                    end else begin
                        hold_nxt = hold + HW'(1);
                    end
                end else begin
                    presc_nxt = presc + PW'(1);
                end
            end

            default: begin
                st_nxt    = S_IDLE;
                presc_nxt = '0;
                hold_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            st           <= S_IDLE;
            presc        <= '0;
            hold         <= '0;
            entry_sec    <= 4'd0;
            entry_tens   <= 4'd0;
            entry_min    <= 4'd0;
            loadn_q      <= 1'b1;
            count_en_q   <= 1'b0;
            timer_clrn_q <= 1'b1;
            mag_on_q     <= 1'b0;
            alarm_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            st           <= st_nxt;
            presc        <= presc_nxt;
            hold         <= hold_nxt;
            entry_sec    <= sec_nxt;
            entry_tens   <= tens_nxt;
            entry_min    <= min_nxt;
            loadn_q      <= loadn_nxt;
            count_en_q   <= count_en_nxt;
            timer_clrn_q <= timer_clrn_nxt;
            mag_on_q     <= (st_nxt == S_COOK);
            alarm_q      <= (st_nxt == S_DONE);
            err_q        <= err_nxt;
        end
    end

    assign bus.loadn      = loadn_q;
    assign bus.count_en   = count_en_q;
    assign bus.timer_clrn = timer_clrn_q;
    assign bus.data_sec   = entry_sec;
    assign bus.data_tens  = entry_tens;
    assign bus.data_min   = entry_min;
    assign bus.mag_on     = mag_on_q;
    assign bus.alarm      = alarm_q;
    assign bus.err        = err_q;
    assign bus.state      = st;

endmodule
